// File: rtl/fpga_ctrl_pkg.sv
// Shared encodings and defaults for the board-level run sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpga_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    localparam logic [1:0] FC_NONE      = 2'd0;
    localparam logic [1:0] FC_DERR_IMEM = 2'd1;
    localparam logic [1:0] FC_DERR_DMEM = 2'd2;
    localparam logic [1:0] FC_LOAD_TMO  = 2'd3;

    localparam int DEF_RST_CYCLES   = 4;
    localparam int DEF_LOAD_TIMEOUT = 256;
    localparam int DEF_RUN_CYCLES   = 64;
    localparam int DEF_CNT_W        = 8;

    // Number of flags high among two, as a 2-bit count.
    function automatic logic [1:0] popcnt2(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

endpackage

// File: rtl/ecc_err_monitor.sv
// ECC flag supervisor: combinational double-error hit/source, saturating single-error count.
// Latency: dbl_hit_o same cycle; serr_count_o updates one cycle after the flags.
// Backpressure: none; flags are sampled every cycle while enabled.
module ecc_err_monitor
    import fpga_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             s_err_imem_i,
    input  logic             s_err_dmem_i,
    input  logic             d_err_imem_i,
    input  logic             d_err_dmem_i,
    output logic             dbl_hit_o,
    output logic [1:0]       dbl_src_o,
    output logic [CNT_W-1:0] serr_count_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       inc;
    logic [CNT_W:0]   sum;

    assign dbl_hit_o = en_i & (d_err_imem_i | d_err_dmem_i);
    // IMEM wins when both memories report an uncorrectable error together.
    assign dbl_src_o = d_err_imem_i ? FC_DERR_IMEM : FC_DERR_DMEM;

    always_comb begin
        inc = en_i ? popcnt2(s_err_imem_i, s_err_dmem_i) : 2'b00;
        sum = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, inc};
        if (clr_i) begin
            cnt_d = '0;
        end else if (sum[CNT_W]) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign serr_count_o = cnt_q;

endmodule

// File: rtl/fpga_run_sequencer.sv
// Run controller: resets loader/CPU, waits for IMEM load, runs a fixed window, captures ResultW, latches ECC faults.
// Latency: all outputs registered; state changes take effect on the edge after the triggering input.
// Backpressure: none; triggers arriving while a run is in flight are dropped.
module fpga_run_sequencer
    import fpga_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOAD_TIMEOUT = DEF_LOAD_TIMEOUT,
    parameter int RUN_CYCLES   = DEF_RUN_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       sw,
    input  logic             loader_done,
    input  logic [31:0]      result_in,
    input  logic             s_err_imem,
    input  logic             s_err_dmem,
    input  logic             d_err_imem,
    input  logic             d_err_dmem,
    output logic             sub_rst_n,
    output logic [2:0]       alu_op,
    output logic [31:0]      result,
    output logic             result_valid,
    output logic             busy,
    output logic             fatal,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] serr_count
);

    localparam int M1 = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
    localparam int M2 = (M1 > LOAD_TIMEOUT) ? M1 : LOAD_TIMEOUT;
    localparam int CW = $clog2(M2 + 1);

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        start_q;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [31:0] result_q, result_d;
    logic        rv_q, rv_d;
    logic        fatal_q, fatal_d;
    logic [1:0]  fc_q, fc_d;
    logic        sub_rst_n_q, sub_rst_n_d;
    logic        busy_q, busy_d;

    logic        start_rise;
    logic        launch;
    logic        ecc_en;
    logic        serr_clr;
    logic        dbl_hit;
    logic [1:0]  dbl_src;

    assign start_rise = start & ~start_q;
    assign ecc_en     = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_DONE);
    // A switch change only restarts a finished run; FAULT needs an explicit start.
    assign launch     = ((state_q == ST_IDLE) || (state_q == ST_FAULT) || (state_q == ST_DONE)) &&
                        (start_rise || ((state_q == ST_DONE) && (sw != alu_op_q)));

    ecc_err_monitor #(.CNT_W(CNT_W)) u_ecc (
        .clk          (clk),
        .rst_n        (rst),
        .en_i         (ecc_en),
        .clr_i        (serr_clr),
        .s_err_imem_i (s_err_imem),
        .s_err_dmem_i (s_err_dmem),
        .d_err_imem_i (d_err_imem),
        .d_err_dmem_i (d_err_dmem),
        .dbl_hit_o    (dbl_hit),
        .dbl_src_o    (dbl_src),
        .serr_count_o (serr_count)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alu_op_d = alu_op_q;
        result_d = result_q;
        rv_d     = rv_q;
        fatal_d  = fatal_q;
        fc_d     = fc_q;
        serr_clr = 1'b0;

        // An uncorrectable error pre-empts load completion, run expiry and restarts.
        if (dbl_hit) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
            rv_d    = 1'b0;
            fatal_d = 1'b1;
            fc_d    = dbl_src;
        end else if (launch) begin
            state_d  = ST_RESET;
            cnt_d    = '0;
            alu_op_d = sw;
            rv_d     = 1'b0;
            fatal_d  = 1'b0;
            fc_d     = FC_NONE;
            serr_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    if (cnt_q == CW'(RST_CYCLES - 1)) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_LOAD: begin
                    if (loader_done) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(LOAD_TIMEOUT - 1)) begin
                        state_d = ST_FAULT;
                        cnt_d   = '0;
                        rv_d    = 1'b0;
                        fatal_d = 1'b1;
                        fc_d    = FC_LOAD_TMO;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CW'(RUN_CYCLES - 1)) begin
                        state_d  = ST_DONE;
                        cnt_d    = '0;
                        result_d = result_in;
                        rv_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end

        // Decode from the next state so the registered outputs line up with state_q.
        sub_rst_n_d = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_DONE);
        busy_d      = (state_d == ST_RESET) || (state_d == ST_LOAD) || (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            alu_op_q    <= 3'b000;
            result_q    <= 32'd0;
            rv_q        <= 1'b0;
            fatal_q     <= 1'b0;
            fc_q        <= FC_NONE;
            sub_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= start;
            alu_op_q    <= alu_op_d;
            result_q    <= result_d;
            rv_q        <= rv_d;
            fatal_q     <= fatal_d;
            fc_q        <= fc_d;
            sub_rst_n_q <= sub_rst_n_d;
            busy_q      <= busy_d;
        end
    end

    assign sub_rst_n    = sub_rst_n_q;
    assign alu_op       = alu_op_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign busy         = busy_q;
    assign fatal        = fatal_q;
    assign fault_code   = fc_q;

endmodule

// File: tb/tb_fpga_run_sequencer.sv
// Directed bench for fpga_run_sequencer with an output scoreboard.
// Expected run outcomes are queued at launch; a negedge monitor checks each capture or fault.
module tb_fpga_run_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  sw = 3'b000;
    logic        loader_done = 1'b0;
    logic [31:0] result_in = 32'd0;
    logic        s_err_imem = 1'b0, s_err_dmem = 1'b0;
    logic        d_err_imem = 1'b0, d_err_dmem = 1'b0;
    logic        sub_rst_n;
    logic [2:0]  alu_op;
    logic [31:0] result;
    logic        result_valid, busy, fatal;
    logic [1:0]  fault_code;
    logic [7:0]  serr_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          is_fault;
        logic [31:0] res;
        logic [2:0]  op;
        logic [1:0]  fc;
        logic [7:0]  serr;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    fpga_run_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sw           (sw),
        .loader_done  (loader_done),
        .result_in    (result_in),
        .s_err_imem   (s_err_imem),
        .s_err_dmem   (s_err_dmem),
        .d_err_imem   (d_err_imem),
        .d_err_dmem   (d_err_dmem),
        .sub_rst_n    (sub_rst_n),
        .alu_op       (alu_op),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .fatal        (fatal),
        .fault_code   (fault_code),
        .serr_count   (serr_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (sub_rst_n == 1'b0 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic push_exp(input bit f, input logic [31:0] r, input logic [2:0] op,
                            input logic [1:0] fc, input logic [7:0] s);
        exp_t e;
        e.is_fault = f; e.res = r; e.op = op; e.fc = fc; e.serr = s;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_output(input bit f);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: fault=%0d with no expected entry", f);
        end else begin
            e = exp_q.pop_front();
            chk("out_kind", 32'(f), 32'(e.is_fault));
            chk("out_result", result, e.res);
            chk("out_fault_code", 32'(fault_code), 32'(e.fc));
            if (f) begin
                chk("fault_result_valid", 32'(result_valid), 32'd0);
                chk("fault_sub_rst_n", 32'(sub_rst_n), 32'd0);
            end else begin
                chk("cap_alu_op", 32'(alu_op), 32'(e.op));
                chk("cap_serr_count", 32'(serr_count), 32'(e.serr));
            end
        end
    endtask

    logic rv_prev = 1'b0, fatal_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (result_valid && !rv_prev) check_output(1'b0);
            if (fatal && !fatal_prev)     check_output(1'b1);
        end
        rv_prev    = result_valid;
        fatal_prev = fatal;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;

        // Power-on reset
        repeat (3) tick();
        chk("rst_sub_rst_n", 32'(sub_rst_n), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fatal", 32'(fatal), 32'd0);
        chk("rst_fault_code", 32'(fault_code), 32'd0);
        chk("rst_serr_count", 32'(serr_count), 32'd0);
        rst = 1'b1;
        repeat (3) tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_sub_rst_n", 32'(sub_rst_n), 32'd0);

        // Run 1: sw=000, result 15
        sw = 3'b000;
        result_in = 32'd15;
        push_exp(1'b0, 32'd15, 3'b000, 2'd0, 8'd0);
        pulse_start();
        chk("run1_busy", 32'(busy), 32'd1);
        count_low(n);
        chk("run1_reset_len", 32'(n), 32'd4);
        repeat (20) tick();
        chk("run1_load_busy", 32'(busy), 32'd1);
        loader_done = 1'b1;
        tick();
        k = 0;
        while (!result_valid && k < 200) begin
            tick();
            k++;
        end
        chk("run1_run_len", 32'(k), 32'd64);
        chk("run1_done_busy", 32'(busy), 32'd0);
        chk("run1_done_sub_rst_n", 32'(sub_rst_n), 32'd1);
        result_in = 32'd99;
        repeat (3) tick();
        chk("run1_result_frozen", result, 32'd15);

        // Run 2: sw change in DONE retriggers, single errors during RUN
        sw = 3'b001;
        result_in = 32'd5;
        loader_done = 1'b0;
        push_exp(1'b0, 32'd5, 3'b001, 2'd0, 8'd4);
        tick();
        chk("run2_rv_drop", 32'(result_valid), 32'd0);
        chk("run2_alu_op", 32'(alu_op), 32'd1);
        count_low(n);
        chk("run2_reset_len", 32'(n), 32'd4);
        loader_done = 1'b1;
        tick();
        k = 0;
        s_err_imem = 1'b1; s_err_dmem = 1'b1;
        tick(); k++;
        chk("serr_both", 32'(serr_count), 32'd2);
        s_err_imem = 1'b0;
        tick(); k++;
        tick(); k++;
        s_err_dmem = 1'b0;
        chk("serr_four", 32'(serr_count), 32'd4);
        while (!result_valid && k < 200) begin
            tick();
            k++;
        end
        chk("run2_run_len", 32'(k), 32'd64);
        s_err_imem = 1'b1;
        repeat (300) tick();
        s_err_imem = 1'b0;
        tick();
        chk("serr_saturate", 32'(serr_count), 32'd255);

        // Run 3: d_err_dmem on the RUN expiry cycle
        loader_done = 1'b0;
        push_exp(1'b1, 32'd5, 3'b001, 2'd2, 8'd0);
        pulse_start();
        chk("run3_serr_clear", 32'(serr_count), 32'd0);
        count_low(n);
        chk("run3_reset_len", 32'(n), 32'd4);
        loader_done = 1'b1;
        tick();
        repeat (63) tick();
        d_err_dmem = 1'b1;
        tick();
        d_err_dmem = 1'b0;
        loader_done = 1'b0;
        chk("run3_fatal", 32'(fatal), 32'd1);
        chk("run3_no_capture", 32'(result_valid), 32'd0);
        chk("run3_busy", 32'(busy), 32'd0);
        sw = 3'b010;
        repeat (3) tick();
        chk("fault_hold_on_sw", 32'(fatal), 32'd1);
        chk("fault_alu_op_hold", 32'(alu_op), 32'd1);

        // Run 4: exit FAULT by start, then load timeout
        push_exp(1'b1, 32'd5, 3'b010, 2'd3, 8'd0);
        pulse_start();
        chk("run4_fatal_clear", 32'(fatal), 32'd0);
        chk("run4_fc_clear", 32'(fault_code), 32'd0);
        chk("run4_busy", 32'(busy), 32'd1);
        chk("run4_alu_op", 32'(alu_op), 32'd2);
        count_low(n);
        chk("run4_reset_len", 32'(n), 32'd4);
        k = 0;
        while (!fatal && k < 400) begin
            tick();
            k++;
        end
        chk("load_timeout_len", 32'(k), 32'd256);

        // Run 5: both double errors in LOAD, IMEM has priority
        push_exp(1'b1, 32'd5, 3'b010, 2'd1, 8'd0);
        pulse_start();
        count_low(n);
        d_err_imem = 1'b1; d_err_dmem = 1'b1;
        tick();
        d_err_imem = 1'b0; d_err_dmem = 1'b0;
        chk("dbl_priority", 32'(fault_code), 32'd1);

        // Run 6: async reset mid-RUN
        pulse_start();
        count_low(n);
        loader_done = 1'b1;
        tick();
        repeat (10) tick();
        chk("run6_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_sub_rst_n", 32'(sub_rst_n), 32'd0);
        chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fatal", 32'(fatal), 32'd0);
        loader_done = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", 32'(busy), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_run_sequencer.md
Name: fpga_run_sequencer

Overview:
- Top-level run controller between board I/O and the loader/CPU pair. Sequences each experiment: hold loader + CPU in reset, release, wait for the loader to finish writing IMEM, let the CPU run a fixed window, then capture ResultW.
- Also supervises the memory ECC flags. Single-error events are counted. Any double error forces a latched fault with the CPU held in reset.
- Sits in top_fpga. Drives the reset and alu_op inputs of instr_loader and Pipeline_top instead of wiring them straight from the board.

Parameters:
- RST_CYCLES, 4: cycles the downstream reset is held low on each (re)start, minimum 1.
- LOAD_TIMEOUT, 256: maximum cycles to wait for loader_done before faulting.
- RUN_CYCLES, 64: cycles the CPU runs after loader_done before the result is captured, minimum 1.
- CNT_W, 8: width of the saturating single-error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset (0 = reset).
- start  in  1  synchronous level; a rising edge requests a new run.
- sw  in  3  ALU op select from the board.
- loader_done  in  1  loader finished writing IMEM.
- result_in  in  32  ResultW from the CPU.
- s_err_imem, s_err_dmem  in  1 each  single-bit-corrected flags.
- d_err_imem, d_err_dmem  in  1 each  uncorrectable flags.
- sub_rst_n  out  1  active-low reset to the loader and CPU.
- alu_op  out  3  registered sw copy, held stable for the whole run.
- result  out  32  captured result.
- result_valid  out  1  result holds a completed run.
- busy  out  1  state is RESET, LOAD or RUN.
- fatal  out  1  latched fault.
- fault_code  out  2  0 none, 1 d_err_imem, 2 d_err_dmem, 3 load timeout.
- serr_count  out  CNT_W  saturating single-error count.

Behaviour:
- Async reset (rst=0) puts the block in IDLE. All outputs are 0, including sub_rst_n=0 and alu_op=0. Internal counters are 0 and the start/sw history registers are cleared.
- Run trigger: a rising edge of start (registered start_q), or sw differing from alu_op while in DONE. A trigger in IDLE, DONE or FAULT does all of the following on that edge:
  - loads alu_op <= sw;
  - clears result_valid, fatal, fault_code and serr_count;
  - sets cnt=0;
  - moves to RESET.
- Triggers are ignored in RESET, LOAD and RUN.
- IDLE: sub_rst_n=0.
- RESET: sub_rst_n=0 for exactly RST_CYCLES cycles, then LOAD.
- LOAD: sub_rst_n=1.
  - loader_done=1 -> RUN with cnt=0.
  - If cnt reaches LOAD_TIMEOUT-1 with loader_done still 0 -> FAULT with code 3.
- RUN: sub_rst_n=1. After RUN_CYCLES cycles in RUN:
  - result <= result_in, sampled on the cycle RUN exits;
  - result_valid <= 1;
  - move to DONE.
- DONE: sub_rst_n=1. The CPU keeps running while result stays frozen.
- FAULT: sub_rst_n=0, fatal=1, result_valid=0, result keeps its last value. The only exit is a start rising edge.
- ECC supervision is active only in LOAD, RUN and DONE, and flags are sampled every clk.
  - Any d_err -> FAULT on the next edge. fault_code=1 if d_err_imem is set, else 2 (imem takes priority when both fire).
  - d_err beats a RUN expiry or loader_done arriving on the same cycle: no capture.
  - serr_count increments by the number of s_err flags high that cycle (0/1/2) and saturates at 2^CNT_W-1 with no wrap.
- busy is a registered decode of the state.
- All outputs are registered. No combinational path from any input to any output.

Decomposition:
- Shared package fpga_ctrl_pkg holds:
  - the state encoding (IDLE, RESET, LOAD, RUN, DONE, FAULT, 3 bits);
  - the fault_code constants;
  - the default RST_CYCLES, LOAD_TIMEOUT and RUN_CYCLES.
- One natural sub-module: ecc_err_monitor. It takes the four flags plus an enable and produces dbl_hit, dbl_src and the saturating serr_count. The FSM stays in fpga_run_sequencer.

Test Plan:
- Power-on with rst=0 for 3 cycles -> all outputs 0, sub_rst_n=0. Release rst -> remains IDLE with busy=0.
- sw=000, start pulse, loader_done asserted 20 cycles after sub_rst_n rises, result_in=32'd15 -> sub_rst_n low exactly 4 cycles; result=15 and result_valid=1 exactly 64 cycles after loader_done; alu_op=000 throughout.
- In DONE change sw 000->001, result_in=32'd5 -> result_valid drops, 4-cycle reset, new run ends with result=5 and alu_op=001.
- During RUN pulse s_err_imem and s_err_dmem together for 1 cycle, then s_err_dmem alone for 2 cycles -> serr_count=4. Force 300 single errors -> serr_count=255.
- d_err_dmem=1 in the same cycle the RUN counter expires -> FAULT, fatal=1, fault_code=2, result_valid=0, sub_rst_n=0. Next start pulse clears fatal and enters RESET.
- loader_done never asserted -> FAULT with fault_code=3 after 256 LOAD cycles. rst pulsed low mid-RUN -> immediate IDLE with all outputs 0.
